// File: rtl/seg_scan_blinker.sv
// N-digit multiplexed seven-segment scanner with hex decode, per-slot guard blanking and a
// fixed-rate blink output. Define SEG_DIGIT_BLINK_EN to blank blink_mask digits while blink is low.
module seg_scan_blinker #(
   parameter int unsigned CLK_HZ        = 24000000,
   parameter int unsigned BLINK_MILLIHZ = 2400,
   parameter int unsigned NUM_DIGITS    = 2,
   parameter int unsigned SCAN_HZ       = 1000,
   parameter int unsigned GUARD_CYCLES  = 1,
   parameter int unsigned ACTIVE_LOW    = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic [4*NUM_DIGITS-1:0]   digits,
   input  logic [NUM_DIGITS-1:0]     blink_mask,
   output logic [6:0]                seg,
   output logic [NUM_DIGITS-1:0]     an,
   output logic                      blink,
   output logic                      slot_tick
);

   // 64-bit product: CLK_HZ*500 overflows 32 bits at the default clock.
   localparam longint unsigned HALF_L = (64'(CLK_HZ) * 64'd500) / 64'(BLINK_MILLIHZ);
   localparam int unsigned HALF = 32'(HALF_L);
   localparam int unsigned SLOT = CLK_HZ / (SCAN_HZ * NUM_DIGITS);
   localparam int unsigned BW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int unsigned SW   = (SLOT > 1) ? $clog2(SLOT) : 1;
   localparam int unsigned IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [BW-1:0] HALF_MAX = BW'(HALF - 1);
   localparam logic [SW-1:0] SLOT_MAX = SW'(SLOT - 1);
   localparam logic [SW-1:0] GUARD_V  = SW'(GUARD_CYCLES);
   localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

   localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

   if (HALF < 1) begin : g_bad_half
      $error("seg_scan_blinker: blink half-period must be at least one cycle");
   end
   if (SLOT <= GUARD_CYCLES) begin : g_bad_slot
      $error("seg_scan_blinker: slot length must exceed GUARD_CYCLES");
   end
   if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("seg_scan_blinker: NUM_DIGITS must be in 1..8");
   end

   logic [BW-1:0]         blink_cnt;
   logic [SW-1:0]         slot_cnt;
   logic [IW-1:0]         idx;
   logic [3:0]            nibble;
   logic [6:0]            seg_hi;
   logic [NUM_DIGITS-1:0] an_hi;

   always_ff @(posedge clk) begin
      if (!reset) begin
         blink_cnt <= '0;
         blink     <= 1'b0;
      end else if (blink_cnt == HALF_MAX) begin
         blink_cnt <= '0;
         blink     <= ~blink;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         slot_cnt  <= '0;
         idx       <= '0;
         slot_tick <= 1'b0;
      end else begin
         slot_tick <= (slot_cnt == SLOT_MAX);
         if (slot_cnt == SLOT_MAX) begin
            slot_cnt <= '0;
            idx      <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
         end else begin
            slot_cnt <= slot_cnt + SW'(1);
         end
      end
   end

   always_comb begin
      nibble = 4'h0;
      an_hi  = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IW'(k)) begin
            nibble   = digits[4*k +: 4];
            an_hi[k] = 1'b1;
         end
      end
      if (!en || slot_cnt < GUARD_V) an_hi = '0;
`ifdef SEG_DIGIT_BLINK_EN
      if (!blink) an_hi = an_hi & ~blink_mask;
`endif
      seg_hi = 7'h00;
      case (nibble)
         4'h0: seg_hi = 7'h3F;
         4'h1: seg_hi = 7'h06;
         4'h2: seg_hi = 7'h5B;
         4'h3: seg_hi = 7'h4F;
         4'h4: seg_hi = 7'h66;
         4'h5: seg_hi = 7'h6D;
         4'h6: seg_hi = 7'h7D;
         4'h7: seg_hi = 7'h07;
         4'h8: seg_hi = 7'h7F;
         4'h9: seg_hi = 7'h6F;
         4'hA: seg_hi = 7'h77;
         4'hB: seg_hi = 7'h7C;
         4'hC: seg_hi = 7'h39;
         4'hD: seg_hi = 7'h5E;
         4'hE: seg_hi = 7'h79;
         4'hF: seg_hi = 7'h71;
         default: seg_hi = 7'h00;
      endcase
   end

`ifndef SEG_DIGIT_BLINK_EN
   logic unused_blink_mask;
   assign unused_blink_mask = ^blink_mask;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         seg <= SEG_OFF;
         an  <= AN_OFF;
      end else begin
         seg <= (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
         an  <= (ACTIVE_LOW != 0) ? ~an_hi : an_hi;
      end
   end

endmodule

// File: tb/tb_seg_scan_blinker.sv
// Directed bench for seg_scan_blinker: closed-form cycle model feeds a scoreboard queue of
// expected outputs that is checked one edge later.
module tb_seg_scan_blinker;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [7:0] digits;
   logic [1:0] blink_mask;
   logic [6:0] seg;
   logic [1:0] an;
   logic       blink;
   logic       slot_tick;

   seg_scan_blinker #(
      .CLK_HZ       (1000),
      .BLINK_MILLIHZ(50000),
      .NUM_DIGITS   (2),
      .SCAN_HZ      (125),
      .GUARD_CYCLES (1),
      .ACTIVE_LOW   (1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .digits    (digits),
      .blink_mask(blink_mask),
      .seg       (seg),
      .an        (an),
      .blink     (blink),
      .slot_tick (slot_tick)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] an;
      logic [6:0] seg;
      logic       blink;
      logic       tick;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int n = 0;  // edges since reset release

   logic [6:0] dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic step();
      exp_t e;
      int s, d;
      logic [3:0] nib;
      if (!reset) begin
         e.an = 2'b11; e.seg = 7'h7F; e.blink = 1'b0; e.tick = 1'b0;
         n = 0;
      end else begin
         s = n % 4;
         d = (n / 4) % 2;
         nib = (d == 1) ? digits[7:4] : digits[3:0];
         e.seg = ~dec[nib];
         e.an = 2'b11;
         if (en && s >= 1) e.an = (d == 1) ? 2'b01 : 2'b10;
`ifdef SEG_DIGIT_BLINK_EN
         if (((n / 10) % 2) == 0) e.an = e.an | blink_mask;
`endif
         e.blink = (((n + 1) / 10) % 2) == 1;
         e.tick = (s == 3);
         n++;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      assert (an === e.an) else begin
         errors++;
         $error("FAIL an: got %b want %b (n=%0d)", an, e.an, n);
      end
      checks++;
      assert (seg === e.seg) else begin
         errors++;
         $error("FAIL seg: got %h want %h (n=%0d)", seg, e.seg, n);
      end
      checks++;
      assert (blink === e.blink) else begin
         errors++;
         $error("FAIL blink: got %b want %b (n=%0d)", blink, e.blink, n);
      end
      checks++;
      assert (slot_tick === e.tick) else begin
         errors++;
         $error("FAIL slot_tick: got %b want %b (n=%0d)", slot_tick, e.tick, n);
      end
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step();
   endtask

   initial begin
      reset = 1'b0;
      en = 1'b1;
      digits = 8'h3A;
      blink_mask = 2'b10;

      // Reset hold, then free run past three blink toggles
      run(3);
      reset = 1'b1;
      run(40);

      // Decode sweep on digit 0, one full slot per value
      for (int v = 0; v < 16; v++) begin
         digits[3:0] = 4'(v);
         run(4);
      end

      // Enable dropped and restored mid-slot
      digits = 8'h3A;
      run(2);
      en = 1'b0;
      run(6);
      en = 1'b1;
      run(6);

      // A few arbitrary data patterns
      for (int i = 0; i < 6; i++) begin
         digits = 8'($urandom);
         run(3);
      end

      // Reset in cycle 2 of the digit-1 slot
      for (int i = 0; i < 8 && (n % 8) != 5; i++) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      run(25);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_blinker.md
Name: seg_scan_blinker

Overview:
- Parametrised successor to the single-digit board-bring-up display and LED blinker.
- Drives an N-digit multiplexed seven-segment display with hex decode, per-slot anti-ghosting blanking, and an exact-rate LED blink generator.
- Sits between the HSOSC-derived system clock and the board pins.
- Takes packed nibbles from user logic; produces registered segment, anode, and blink outputs.

Parameters:
- CLK_HZ, 24000000, input clock frequency in Hz (HSOSC with CLKHF_DIV=2'b01).
- BLINK_MILLIHZ, 2400, blink frequency in mHz. Half-period HALF = CLK_HZ*500/BLINK_MILLIHZ cycles, integer division.
- NUM_DIGITS, 2, number of multiplexed digits (1..8).
- SCAN_HZ, 1000, full-display refresh rate. Slot length SLOT = CLK_HZ/(SCAN_HZ*NUM_DIGITS) cycles.
- GUARD_CYCLES, 1, cycles at the start of each slot with all anodes off.
- ACTIVE_LOW, 1, when 1 the seg and an pins are active-low; when 0 they are active-high.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset.
- en  input  1  display enable; 0 turns all anodes inactive.
- digits  input  4*NUM_DIGITS  hex nibbles; digit k = digits[4k+3:4k], digit 0 first in the scan.
- blink_mask  input  NUM_DIGITS  per-digit blink select (used only with the optional feature).
- seg  output  7  segments, seg[0]=a .. seg[6]=g.
- an  output  NUM_DIGITS  digit anode selects.
- blink  output  1  square wave at BLINK_MILLIHZ, 50% duty.
- slot_tick  output  1  one-cycle pulse on the last cycle of each slot.

Behaviour:
- Reset: reset, synchronous, active-low.
  - While reset=0 at a clock edge: blink_cnt=0, slot_cnt=0, idx=0, blink=0, slot_tick=0.
  - an and seg go all-inactive: all 1s if ACTIVE_LOW, else all 0s.
  - Asserting reset mid-slot or mid-blink restarts every count from 0 on the next edge. There is no partial-state carryover.
- Elaboration checks: HALF>=1, SLOT>GUARD_CYCLES, and 1<=NUM_DIGITS<=8. Any violation is reported with $error.
- Blink counter:
  - blink_cnt counts 0..HALF-1.
  - At the edge where blink_cnt==HALF-1, blink_cnt wraps to 0 and blink toggles.
  - The first toggle is at the HALF-th edge after reset release.
  - The counter is independent of en.
- Scan counter:
  - slot_cnt counts 0..SLOT-1.
  - At the edge where slot_cnt==SLOT-1, slot_cnt wraps to 0 and idx advances; idx wraps NUM_DIGITS-1 -> 0.
  - slot_tick is registered: it is high for the single cycle after the edge that sampled slot_cnt==SLOT-1.
  - The counter runs regardless of en.
- Output registers (1-cycle latency from the pre-edge slot_cnt, idx, digits, and en):
  - If en=0 or slot_cnt<GUARD_CYCLES, all anodes are inactive.
  - Otherwise only an[idx] is active.
  - seg = decode(digits nibble idx), with the polarity set by ACTIVE_LOW.
  - seg is updated every cycle, including guard cycles. Data changes mid-slot appear on the next edge.
- Decode, active-high gfedcba:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- NUM_DIGITS=1: idx stays 0, and the guard is still applied every slot.

Optional Feature:
- Macro: SEG_DIGIT_BLINK_EN.
- Defined: a digit k with blink_mask[k]=1 has its anode forced inactive whenever blink==0. The blink value is the registered blink seen by the output stage. The guard and en rules still apply.
- Undefined: blink_mask is ignored and digits are never blanked by blink. blink stays on its own port.

Test Plan (CLK_HZ=1000, BLINK_MILLIHZ=50000 -> HALF=10; NUM_DIGITS=2, SCAN_HZ=125 -> SLOT=4; GUARD_CYCLES=1; ACTIVE_LOW=1):
- Reset: hold reset=0 for 3 cycles with digits=8'h3A, en=1 -> an=2'b11, seg=7'h7F, blink=0, slot_tick=0. Release reset -> blink rises at edge 10, falls at 20, rises at 30.
- Scan: digits=8'h3A, en=1 -> each 4-cycle slot shows an=11 for 1 cycle then the digit for 3 cycles.
  - Digit 0: an=2'b10 with seg=7'h08.
  - Digit 1: an=2'b01 with seg=7'h30.
  - slot_tick pulses once per 4 cycles.
- Decode sweep: step digit 0 through 0..F -> seg matches the inverted table for every value, e.g. 8 -> 7'h00 and F -> 7'h0E.
- Enable: drop en mid-slot -> an=11 on the next edge while slot_tick timing is unchanged. Raise en -> the current idx is shown on the next edge unless in a guard cycle.
- Reset mid-operation: assert reset=0 in cycle 2 of the digit-1 slot -> outputs inactive on the next edge. After release, digit 0 is the first shown and blink restarts at a 10-cycle half-period.
- With SEG_DIGIT_BLINK_EN and blink_mask=2'b10: digit 1's anode is inactive whenever blink=0, digit 0 is unaffected. Without the macro, both digits always display.
